// File: rtl/idx_cmp_pkg.sv
// Shared types and helpers for the multi-lane index comparator.
// Codes describe the reference relative to each lane index.
package idx_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_NONE = 2'b00,
    CMP_LT   = 2'b01,
    CMP_EQ   = 2'b10,
    CMP_GT   = 2'b11
  } cmp_code_t;

  function automatic logic [31:0] popcnt(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++)
      n = n + 32'(v[i]);
    return n;
  endfunction

  // Lowest set bit wins; zero when nothing is set.
  function automatic logic [31:0] prienc(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) r = 32'(i);
    return r;
  endfunction

endpackage

// File: rtl/idx_cmp_array_if.sv
// Index beat in / result beat out, both valid/ready.
// slave is the comparator side, master the stream side.
interface idx_cmp_array_if #(
  parameter int IDX_W = 4,
  parameter int LANES = 4,
  parameter int CNT_W = 8,
  parameter int FE_W  = (LANES > 1) ? $clog2(LANES) : 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IDX_W-1:0] in_idx;
  logic [LANES-1:0]       in_lmask;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*2-1:0]     cmp_code;
  logic [LANES-1:0]       eq_mask;
  logic [LANES-1:0]       gt_mask;
  logic                   any_eq;
  logic [FE_W-1:0]        first_eq;
  logic                   all_past;
  logic [CNT_W-1:0]       match_cnt;

  modport slave (
    input  in_valid, in_idx, in_lmask, out_ready,
    output in_ready, out_valid, cmp_code, eq_mask,
    output gt_mask, any_eq, first_eq, all_past,
    output match_cnt
  );

  modport master (
    output in_valid, in_idx, in_lmask, out_ready,
    input  in_ready, out_valid, cmp_code, eq_mask,
    input  gt_mask, any_eq, first_eq, all_past,
    input  match_cnt
  );
endinterface

// File: rtl/idx_cmp_lane.sv
// Single-lane unsigned compare of reference against one index.
// Masked lanes report CMP_NONE.
module idx_cmp_lane
  import idx_cmp_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [IDX_W-1:0] ref_idx,
  input  logic             lane_valid,
  output cmp_code_t        code
);

  always_comb begin
    code = CMP_NONE;
    if (lane_valid) begin
      unique case (1'b1)
        (ref_idx < idx):  code = CMP_LT;
        (ref_idx == idx): code = CMP_EQ;
        default:          code = CMP_GT;
      endcase
    end
  end

endmodule

// File: rtl/idx_cmp_array.sv
// Two-stage pipelined multi-lane index comparator with a
// saturating match counter for the row-sparse SpMM datapath.
module idx_cmp_array
  import idx_cmp_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ref_load,
  input  logic [IDX_W-1:0] ref_in,
  input  logic             cnt_clr,
  idx_cmp_array_if.slave   bus
);

  localparam int FE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic [IDX_W-1:0]       ref_q;
  logic                   s1_valid;
  logic [LANES*IDX_W-1:0] s1_idx;
  logic [LANES-1:0]       s1_lmask;
  logic [IDX_W-1:0]       s1_ref;

  logic                   s2_valid;
  logic [LANES*2-1:0]     s2_code;
  logic [LANES-1:0]       s2_eq;
  logic [LANES-1:0]       s2_gt;
  logic                   s2_any;
  logic [FE_W-1:0]        s2_first;
  logic                   s2_past;
  logic [CNT_W-1:0]       cnt_q;

  logic s1_adv, s2_adv, accept, deliver;

  cmp_code_t          code [LANES];
  logic [LANES*2-1:0] c_code;
  logic [LANES-1:0]   c_eq;
  logic [LANES-1:0]   c_gt;
  logic [FE_W-1:0]    c_first;
  logic               c_past;
  logic [63:0]        cnt_sum;
  logic [CNT_W-1:0]   cnt_d;

  assign s2_adv  = !s2_valid || bus.out_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign accept  = bus.in_valid && s1_adv;
  assign deliver = s2_valid && bus.out_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    idx_cmp_lane #(.IDX_W(IDX_W)) u_lane (
      .idx        (s1_idx[k*IDX_W +: IDX_W]),
      .ref_idx    (s1_ref),
      .lane_valid (s1_lmask[k]),
      .code       (code[k])
    );
    assign c_code[2*k +: 2] = code[k];
    assign c_eq[k] = (code[k] == CMP_EQ);
    assign c_gt[k] = (code[k] == CMP_LT);
  end

  always_comb begin
    c_first = FE_W'(prienc(32'(c_eq)));
    c_past  = (|s1_lmask) && (c_gt == s1_lmask);
  end

  // Clear wins over the stored value but not over the beat being delivered.
  always_comb begin
    cnt_sum = cnt_clr ? 64'd0 : 64'(cnt_q);
    if (deliver)
      cnt_sum = cnt_sum + 64'(popcnt(32'(s2_eq)));
    cnt_d = (cnt_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(cnt_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q    <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_lmask <= '0;
      s1_ref   <= '0;
      s2_valid <= 1'b0;
      s2_code  <= '0;
      s2_eq    <= '0;
      s2_gt    <= '0;
      s2_any   <= 1'b0;
      s2_first <= '0;
      s2_past  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (ref_load)
        ref_q <= ref_in;
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (accept) begin
          s1_idx   <= bus.in_idx;
          s1_lmask <= bus.in_lmask;
          s1_ref   <= ref_q;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_code  <= c_code;
          s2_eq    <= c_eq;
          s2_gt    <= c_gt;
          s2_any   <= |c_eq;
          s2_first <= c_first;
          s2_past  <= c_past;
        end
      end
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.cmp_code  = s2_code;
  assign bus.eq_mask   = s2_eq;
  assign bus.gt_mask   = s2_gt;
  assign bus.any_eq    = s2_any;
  assign bus.first_eq  = s2_first;
  assign bus.all_past  = s2_past;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_idx_cmp_array.sv
// Scoreboard bench for idx_cmp_array: directed cases plus random
// traffic against a lane-by-lane arithmetic reference model.
module tb_idx_cmp_array;

  localparam int IDX_W = 4;
  localparam int LANES = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [7:0] code;
    logic [3:0] eq;
    logic [3:0] gt;
    logic       any;
    logic [1:0] fe;
    logic       ap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ref_load = 1'b0;
  logic [3:0] ref_in = '0;
  logic       cnt_clr = 1'b0;

  idx_cmp_array_if #(.IDX_W(IDX_W), .LANES(LANES), .CNT_W(CNT_W)) bus ();

  idx_cmp_array #(.IDX_W(IDX_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ref_load (ref_load),
    .ref_in   (ref_in),
    .cnt_clr  (cnt_clr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   model_cnt = 0;
  logic [3:0] model_ref = '0;
  exp_t sb [$];
  exp_t held;
  logic stall = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: per-lane arithmetic on plain integers.
  function automatic exp_t model(input logic [15:0] idx,
                                 input logic [3:0] m, input int r);
    exp_t e;
    e = '0;
    for (int k = 0; k < LANES; k++) begin
      int v, c;
      v = int'(idx[k*4 +: 4]);
      if (!m[k])      c = 0;
      else if (r < v) c = 1;
      else if (r == v) c = 2;
      else            c = 3;
      e.code[k*2 +: 2] = 2'(c);
      e.eq[k] = (c == 2);
      e.gt[k] = (c == 1);
    end
    e.any = |e.eq;
    for (int k = LANES - 1; k >= 0; k--)
      if (e.eq[k]) e.fe = 2'(k);
    e.ap = (m != 0) && (e.gt == m);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [15:0] idx,
                       input logic [3:0] m, input logic rl,
                       input logic [3:0] rin, input logic ordy,
                       input logic clr);
    bus.in_valid  = v;
    bus.in_idx    = idx;
    bus.in_lmask  = m;
    ref_load      = rl;
    ref_in        = rin;
    bus.out_ready = ordy;
    cnt_clr       = clr;
    @(negedge clk);
    if (rst_n && v && bus.in_ready) begin
      sb.push_back(model(idx, m, int'(model_ref)));
      n_acc++;
    end
    if (rst_n && rl) model_ref = rin;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out();
    bus.in_valid = 1'b0;
    ref_load = 1'b0;
    cnt_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("wait_out", 64'(bus.out_valid), 64'd1);
  endtask

  // Monitor: counter model, hold stability and scoreboard pops.
  always @(negedge clk) begin
    exp_t cur, e;
    int   nxt;
    cur = {bus.cmp_code, bus.eq_mask, bus.gt_mask,
           bus.any_eq, bus.first_eq, bus.all_past};
    if (!rst_n) begin
      model_cnt = 0;
      stall = 1'b0;
    end else begin
      chk("match_cnt", 64'(bus.match_cnt), 64'(model_cnt));
      if (stall) chk("hold", 64'(cur), 64'(held));
      nxt = cnt_clr ? 0 : model_cnt;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious: got result %0h expected none", cur);
        end else begin
          e = sb.pop_front();
          chk("result", 64'(cur), 64'(e));
          nxt = nxt + $countones(e.eq);
          if (nxt > CMAX) nxt = CMAX;
        end
      end
      model_cnt = nxt;
      stall = bus.out_valid && !bus.out_ready;
      held = cur;
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_idx    = '0;
    bus.in_lmask  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst cmp_code", 64'(bus.cmp_code), 64'd0);
    chk("rst match_cnt", 64'(bus.match_cnt), 64'd0);
    chk("rst all_past", 64'(bus.all_past), 64'd0);
    @(posedge clk);
    #1;

    // Basic compare
    drive(0, 16'h0, 4'h0, 1, 4'd5, 1, 0);
    drive(1, {4'd5, 4'd7, 4'd5, 4'd3}, 4'hF, 0, 0, 1, 0);
    wait_out();
    chk("t1 code", 64'(bus.cmp_code), 64'b10011011);
    chk("t1 eq", 64'(bus.eq_mask), 64'b1010);
    chk("t1 gt", 64'(bus.gt_mask), 64'b0100);
    chk("t1 first_eq", 64'(bus.first_eq), 64'd1);
    chk("t1 any_eq", 64'(bus.any_eq), 64'd1);
    chk("t1 all_past", 64'(bus.all_past), 64'd0);
    @(posedge clk);
    #1;
    chk("t1 match_cnt", 64'(bus.match_cnt), 64'd2);

    // Masking and all_past
    drive(0, 16'h0, 4'h0, 1, 4'd2, 1, 0);
    drive(1, {4'd15, 4'd8, 4'd1, 4'd9}, 4'b1101, 0, 0, 1, 0);
    drive(1, 16'h1234, 4'b0000, 0, 0, 1, 0);
    wait_out();
    chk("t2 all_past", 64'(bus.all_past), 64'd1);
    chk("t2 any_eq", 64'(bus.any_eq), 64'd0);
    chk("t2 lane1", 64'(bus.cmp_code[3:2]), 64'd0);
    @(negedge clk);
    chk("t2 nomask valid", 64'(bus.out_valid), 64'd1);
    chk("t2 nomask past", 64'(bus.all_past), 64'd0);
    chk("t2 nomask code", 64'(bus.cmp_code), 64'd0);
    @(posedge clk);
    #1;

    // Ref load in the accept cycle
    drive(0, 16'h0, 4'h0, 1, 4'd0, 1, 0);
    drive(1, 16'h4444, 4'hF, 1, 4'd4, 1, 0);
    drive(1, 16'h4444, 4'hF, 0, 0, 1, 0);
    wait_out();
    chk("t4 beat A", 64'(bus.cmp_code), 64'h55);
    @(negedge clk);
    chk("t4 beat B", 64'(bus.cmp_code), 64'hAA);
    @(posedge clk);
    #1;

    // Saturating counter, all-ones equality
    drive(0, 16'h0, 4'h0, 1, 4'd15, 1, 1);
    for (int j = 0; j < 3; j++) begin
      drive(1, 16'hFFFF, 4'hF, 0, 0, 1, 0);
      wait_out();
      @(posedge clk);
      #1;
      chk("t5 sat", 64'(bus.match_cnt), (j == 0) ? 64'd4 : 64'd7);
    end
    drive(1, 16'h00FF, 4'hF, 0, 0, 0, 0);
    repeat (3) drive(0, 16'h0, 4'h0, 0, 0, 0, 0);
    drive(0, 16'h0, 4'h0, 0, 0, 1, 1);
    chk("t5 clr+hs", 64'(bus.match_cnt), 64'd2);

    // Backpressure
    begin
      int start, i;
      start = n_acc;
      i = 0;
      while (n_acc < start + 6 && i < 40) begin
        drive(1, 16'($urandom), 4'hF, 0, 0, (i >= 4), 0);
        if (i == 1) begin
          chk("t3 in_ready", 64'(bus.in_ready), 64'd0);
          chk("t3 out_valid", 64'(bus.out_valid), 64'd1);
        end
        i++;
      end
      chk("t3 accepted", 64'(n_acc - start), 64'd6);
    end

    // Random traffic
    repeat (400) begin
      logic [15:0] ix;
      for (int k = 0; k < LANES; k++)
        ix[k*4 +: 4] = ($urandom_range(0, 1) == 1) ? model_ref
                                                    : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 9) < 7), ix, 4'($urandom),
            ($urandom_range(0, 4) == 0), 4'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end

    // Reset with beats in flight
    drive(0, 16'h0, 4'h0, 1, 4'd9, 1, 0);
    drive(1, 16'h9999, 4'hF, 0, 0, 1, 0);
    drive(1, 16'h9999, 4'hF, 0, 0, 1, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6 out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6 match_cnt", 64'(bus.match_cnt), 64'd0);
    sb.delete();
    model_ref = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6 quiet", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    drive(1, 16'h0000, 4'hF, 0, 0, 1, 0);

    // Drain
    bus.in_valid = 1'b0;
    ref_load = 1'b0;
    cnt_clr = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
